// File: rtl/mat_switch_pkg.sv
// Shared types for the matrix-core switch port: receive FSM states, the
// {core index, vector} entry carried by both FIFOs, and default constants.
package mat_switch_pkg;

  typedef enum logic {MSR_IDLE, MSR_REQ} MatSwitchRecvState_t;

  // One vector element is carried as the raw 32-bit IEEE-754 single pattern.
  typedef logic [31:0] msw_word_t;

  localparam int MSW_DEF_WIDTH       = 16;
  localparam int MSW_DEF_ADDR_W      = 2;
  localparam int MSW_TIMEOUT_DEFAULT = 256;

  typedef struct packed {
    logic [MSW_DEF_ADDR_W-1:0]        core_idx;
    msw_word_t [MSW_DEF_WIDTH-1:0]    data;
  } mat_switch_entry_t;

  function automatic bit msw_is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/mat_switch_fifo.sv
// Synchronous FIFO of switch entries; refuses pushes while full even if a pop
// happens in the same cycle, and presents zero on rdata whenever it is empty.
module mat_switch_fifo
  import mat_switch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = mat_switch_entry_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wdata,
  output entry_t                   rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     not_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             do_push, do_pop;

  assign not_full = (cnt_q < FULL_CNT);
  assign do_push  = push && not_full;
  assign do_pop   = pop && (cnt_q != '0);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count masks stale entries off rdata.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rdata = (cnt_q != '0) ? mem_q[rptr_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/mat_switch_port.sv
// Buffered switch endpoint: send FIFO drained on ready/ok, single-outstanding
// receive request buffered into a receive FIFO. Optional MAT_SWITCH_PORT_TIMEOUT_EN.
module mat_switch_port
  import mat_switch_pkg::*;
#(
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SEND_DEPTH            = 4,
  parameter int RECV_DEPTH            = 4,
  parameter int TIMEOUT_CYCLES        = MSW_TIMEOUT_DEFAULT,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              tx_valid,
  input  logic [SWITCH_CORE_ADDR_SIZE-1:0]  tx_core_idx,
  input  msw_word_t [SWITCH_WIDTH-1:0]      tx_data,
  output logic                              tx_ready,
  input  logic                              rx_req,
  input  logic [SWITCH_CORE_ADDR_SIZE-1:0]  rx_req_core_idx,
  output logic                              rx_req_ready,
  output logic                              rx_valid,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0]  rx_core_idx,
  output msw_word_t [SWITCH_WIDTH-1:0]      rx_data,
  input  logic                              rx_pop,
  output logic                              switch_send_ready,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0]  switch_send_core_idx,
  output msw_word_t [SWITCH_WIDTH-1:0]      switch_send_data,
  input  logic                              switch_send_ok,
  output logic                              switch_recv_request,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0]  switch_recv_core_idx,
  input  logic                              switch_recv_ready,
  input  msw_word_t [SWITCH_WIDTH-1:0]      switch_recv_data,
  output logic [$clog2(SEND_DEPTH):0]       send_count,
  output logic [$clog2(RECV_DEPTH):0]       recv_count,
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
  output logic                              rx_timeout,
`endif
  output logic                              idle
);

  if (!msw_is_pow2(SEND_DEPTH) || SEND_DEPTH < 2 || !msw_is_pow2(RECV_DEPTH) ||
      RECV_DEPTH < 2 || SWITCH_CORE_SIZE < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mat_switch_port: unsupported parameter combination");
  end

  typedef struct packed {
    logic [SWITCH_CORE_ADDR_SIZE-1:0] core_idx;
    msw_word_t [SWITCH_WIDTH-1:0]     data;
  } entry_t;

  entry_t send_wdata, send_rdata, recv_wdata, recv_rdata;
  logic   send_push, send_pop, send_not_full;
  logic   recv_push, recv_pop, recv_not_full;

  // Send path
  assign send_wdata        = {tx_core_idx, tx_data};
  assign tx_ready          = send_not_full;
  assign send_push         = tx_valid && tx_ready;
  assign switch_send_ready = (send_count != '0);
  assign send_pop          = switch_send_ready && switch_send_ok;

  mat_switch_fifo #(
    .DEPTH   (SEND_DEPTH),
    .entry_t (entry_t)
  ) u_send_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (send_push),
    .pop      (send_pop),
    .wdata    (send_wdata),
    .rdata    (send_rdata),
    .count    (send_count),
    .not_full (send_not_full)
  );

  assign switch_send_core_idx = send_rdata.core_idx;
  assign switch_send_data     = send_rdata.data;

  // Receive FSM
  MatSwitchRecvState_t              state_q, state_d;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] req_idx_q, req_idx_d;

`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rx_timeout_q, rx_timeout_d;
`endif

  // Gated by reset so the handshake reads low while the block is held in reset.
  assign rx_req_ready = reset && (state_q == MSR_IDLE) && recv_not_full;

  always_comb begin
    state_d   = state_q;
    req_idx_d = req_idx_q;
    recv_push = 1'b0;
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
    tmo_d        = tmo_q;
    rx_timeout_d = 1'b0;
`endif
    case (state_q)
      MSR_IDLE: begin
        if (rx_req && rx_req_ready) begin
          req_idx_d = rx_req_core_idx;
          state_d   = MSR_REQ;
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end
      end
      MSR_REQ: begin
        if (switch_recv_ready) begin
          recv_push = 1'b1;
          state_d   = MSR_IDLE;
        end
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d      = MSR_IDLE;
          rx_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = MSR_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= MSR_IDLE;
      req_idx_q    <= '0;
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
      tmo_q        <= '0;
      rx_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_idx_q    <= req_idx_d;
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
      tmo_q        <= tmo_d;
      rx_timeout_q <= rx_timeout_d;
`endif
    end
  end

`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
  assign rx_timeout = rx_timeout_q;
`endif

  assign switch_recv_request  = (state_q == MSR_REQ);
  assign switch_recv_core_idx = switch_recv_request ? req_idx_q : '0;

  // Receive FIFO: a slot is always free here because acceptance required one.
  assign recv_wdata = {req_idx_q, switch_recv_data};
  assign rx_valid   = (recv_count != '0);
  assign recv_pop   = rx_pop && rx_valid;

  mat_switch_fifo #(
    .DEPTH   (RECV_DEPTH),
    .entry_t (entry_t)
  ) u_recv_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (recv_push),
    .pop      (recv_pop),
    .wdata    (recv_wdata),
    .rdata    (recv_rdata),
    .count    (recv_count),
    .not_full (recv_not_full)
  );

  assign rx_core_idx = recv_rdata.core_idx;
  assign rx_data     = recv_rdata.data;

  assign idle = (send_count == '0) && (recv_count == '0) && (state_q == MSR_IDLE);

endmodule

// File: tb/tb_mat_switch_port.sv
// Directed self-checking bench for mat_switch_port (default 16x4, depths 4).
module tb_mat_switch_port;
  import mat_switch_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic tx_valid, tx_ready, rx_req, rx_req_ready, rx_valid, rx_pop;
  logic [1:0] tx_core_idx, rx_req_core_idx, rx_core_idx;
  logic [1:0] switch_send_core_idx, switch_recv_core_idx;
  msw_word_t [15:0] tx_data, rx_data, switch_send_data, switch_recv_data;
  logic switch_send_ready, switch_send_ok, switch_recv_request, switch_recv_ready;
  logic [2:0] send_count, recv_count;
  logic idle;
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
  logic rx_timeout;
`endif

  int n_pass = 0;
  int n_total = 0;

  localparam msw_word_t F1P5 = 32'h3FC0_0000; // 1.5 as IEEE single

  mat_switch_port #(
    .SWITCH_WIDTH(16), .SWITCH_CORE_SIZE(4), .SEND_DEPTH(4), .RECV_DEPTH(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .tx_valid(tx_valid), .tx_core_idx(tx_core_idx), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_req_core_idx(rx_req_core_idx), .rx_req_ready(rx_req_ready),
    .rx_valid(rx_valid), .rx_core_idx(rx_core_idx), .rx_data(rx_data), .rx_pop(rx_pop),
    .switch_send_ready(switch_send_ready), .switch_send_core_idx(switch_send_core_idx),
    .switch_send_data(switch_send_data), .switch_send_ok(switch_send_ok),
    .switch_recv_request(switch_recv_request), .switch_recv_core_idx(switch_recv_core_idx),
    .switch_recv_ready(switch_recv_ready), .switch_recv_data(switch_recv_data),
    .send_count(send_count), .recv_count(recv_count),
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
    .rx_timeout(rx_timeout),
`endif
    .idle(idle)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic msw_word_t [15:0] mk_vec(input int tag);
    msw_word_t [15:0] v;
    for (int j = 0; j < 16; j++) v[j] = 32'h4100_0000 | (tag << 8) | j;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    tx_valid = 0; tx_core_idx = 0; tx_data = '0; rx_req = 0; rx_req_core_idx = 0;
    rx_pop = 0; switch_send_ok = 0; switch_recv_ready = 0; switch_recv_data = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    #3;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); else n_pass++;
    n_total++; if (rx_req_ready !== 1'b0) $display("FAIL rst_rx_req_ready got=%b exp=0", rx_req_ready); else n_pass++;
    n_total++; if ({switch_send_ready, switch_recv_request, rx_valid} !== 3'b000)
      $display("FAIL rst_valids got=%b exp=000", {switch_send_ready, switch_recv_request, rx_valid}); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL rst_idle got=%b exp=1", idle); else n_pass++;
    n_total++; if ({send_count, recv_count} !== 6'd0) $display("FAIL rst_counts got=%0d/%0d exp=0/0", send_count, recv_count); else n_pass++;
    n_total++; if (switch_send_data !== '0 || rx_data !== '0 || rx_core_idx !== 2'd0)
      $display("FAIL rst_data got=%h/%h exp=0", switch_send_data[0], rx_data[0]); else n_pass++;
    @(negedge clock);
    reset = 1;
    tick();
    n_total++; if (rx_req_ready !== 1'b1) $display("FAIL post_rst_rx_req_ready got=%b exp=1", rx_req_ready); else n_pass++;
  endtask

  task automatic test_send_fill_drain();
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1; tx_core_idx = 2'(i); tx_data = mk_vec(i);
      tick();
      if (i == 0) begin
        n_total++; if (switch_send_ready !== 1'b1 || switch_send_core_idx !== 2'd0)
          $display("FAIL send_latency got=%b/%0d exp=1/0", switch_send_ready, switch_send_core_idx); else n_pass++;
      end
    end
    n_total++; if (tx_ready !== 1'b0 || send_count !== 3'd4)
      $display("FAIL send_full got=%b/%0d exp=0/4", tx_ready, send_count); else n_pass++;
    tx_core_idx = 2'd3; tx_data = mk_vec(9);
    tick();
    tx_valid = 0;
    n_total++; if (send_count !== 3'd4) $display("FAIL send_refuse_count got=%0d exp=4", send_count); else n_pass++;
    switch_send_ok = 1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (switch_send_core_idx !== 2'(i) || switch_send_data[0] !== mk_vec(i)[0] ||
                     switch_send_data[15] !== mk_vec(i)[15])
        $display("FAIL send_order_%0d got=%0d/%h exp=%0d/%h", i, switch_send_core_idx,
                 switch_send_data[15], i, mk_vec(i)[15]); else n_pass++;
      tick();
    end
    n_total++; if (send_count !== 3'd0 || switch_send_ready !== 1'b0 || switch_send_data !== '0)
      $display("FAIL send_drained got=%0d/%b exp=0/0", send_count, switch_send_ready); else n_pass++;
    tick();
    switch_send_ok = 0;
    n_total++; if (send_count !== 3'd0) $display("FAIL send_ok_empty got=%0d exp=0", send_count); else n_pass++;
  endtask

  task automatic test_send_push_pop();
    tx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tx_core_idx = 2'(i); tx_data = mk_vec(i + 4);
      tick();
    end
    tx_core_idx = 2'd1; tx_data = mk_vec(12); switch_send_ok = 1;
    tick();
    n_total++; if (send_count !== 3'd3 || switch_send_core_idx !== 2'd1 || switch_send_data[0] !== mk_vec(5)[0])
      $display("FAIL full_push_pop got=%0d/%0d exp=3/1", send_count, switch_send_core_idx); else n_pass++;
    tick();
    n_total++; if (send_count !== 3'd3) $display("FAIL push_pop_same got=%0d exp=3", send_count); else n_pass++;
    tx_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    switch_send_ok = 0;
    n_total++; if (send_count !== 3'd0 || idle !== 1'b1) $display("FAIL push_pop_drain got=%0d/%b exp=0/1", send_count, idle); else n_pass++;
  endtask

  task automatic test_recv_basic();
    rx_req = 1; rx_req_core_idx = 2'd2;
    tick();
    rx_req = 0;
    n_total++; if (switch_recv_request !== 1'b1 || switch_recv_core_idx !== 2'd2 || rx_req_ready !== 1'b0 || idle !== 1'b0)
      $display("FAIL recv_req got=%b/%0d/%b exp=1/2/0", switch_recv_request, switch_recv_core_idx, rx_req_ready); else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    n_total++; if (switch_recv_request !== 1'b1 || rx_valid !== 1'b0)
      $display("FAIL recv_wait got=%b/%b exp=1/0", switch_recv_request, rx_valid); else n_pass++;
    switch_recv_ready = 1; switch_recv_data = '0; switch_recv_data[0] = F1P5;
    tick();
    switch_recv_ready = 0; switch_recv_data = '0;
    n_total++; if (switch_recv_request !== 1'b0 || rx_valid !== 1'b1 || rx_core_idx !== 2'd2 || rx_data[0] !== F1P5)
      $display("FAIL recv_capture got=%b/%b/%0d/%h exp=0/1/2/3fc00000", switch_recv_request, rx_valid, rx_core_idx, rx_data[0]); else n_pass++;
    switch_recv_ready = 1;
    tick();
    switch_recv_ready = 0;
    n_total++; if (recv_count !== 3'd1) $display("FAIL recv_idle_ignore got=%0d exp=1", recv_count); else n_pass++;
    rx_pop = 1;
    tick();
    n_total++; if (rx_valid !== 1'b0 || rx_data !== '0 || rx_core_idx !== 2'd0)
      $display("FAIL recv_pop got=%b/%h exp=0/0", rx_valid, rx_data[0]); else n_pass++;
    tick();
    rx_pop = 0;
    n_total++; if (recv_count !== 3'd0) $display("FAIL recv_pop_empty got=%0d exp=0", recv_count); else n_pass++;
  endtask

  task automatic test_recv_fill();
    for (int i = 0; i < 4; i++) begin
      rx_req = 1; rx_req_core_idx = 2'(i);
      tick();
      rx_req = 0; switch_recv_ready = 1; switch_recv_data = mk_vec(20 + i);
      tick();
      switch_recv_ready = 0;
    end
    n_total++; if (recv_count !== 3'd4 || rx_req_ready !== 1'b0 || rx_core_idx !== 2'd0 || rx_data[3] !== mk_vec(20)[3])
      $display("FAIL recv_full got=%0d/%b/%0d exp=4/0/0", recv_count, rx_req_ready, rx_core_idx); else n_pass++;
    rx_req = 1; rx_req_core_idx = 2'd1;
    tick();
    rx_req = 0;
    n_total++; if (switch_recv_request !== 1'b0) $display("FAIL recv_full_refuse got=%b exp=0", switch_recv_request); else n_pass++;
    rx_pop = 1;
    tick();
    rx_pop = 0;
    n_total++; if (rx_req_ready !== 1'b1 || recv_count !== 3'd3 || rx_core_idx !== 2'd1)
      $display("FAIL recv_pop_ready got=%b/%0d/%0d exp=1/3/1", rx_req_ready, recv_count, rx_core_idx); else n_pass++;
    rx_req = 1; rx_req_core_idx = 2'd3;
    tick();
    rx_req = 0; switch_recv_ready = 1; switch_recv_data = mk_vec(30); rx_pop = 1;
    tick();
    switch_recv_ready = 0; rx_pop = 0;
    n_total++; if (recv_count !== 3'd3 || rx_core_idx !== 2'd2)
      $display("FAIL recv_pop_capture got=%0d/%0d exp=3/2", recv_count, rx_core_idx); else n_pass++;
    rx_pop = 1;
    for (int i = 0; i < 3; i++) tick();
    rx_pop = 0;
    n_total++; if (recv_count !== 3'd0 || idle !== 1'b1) $display("FAIL recv_drain got=%0d/%b exp=0/1", recv_count, idle); else n_pass++;
  endtask

  task automatic test_reset_mid();
    tx_valid = 1;
    for (int i = 0; i < 2; i++) begin
      tx_core_idx = 2'(i + 1); tx_data = mk_vec(40 + i);
      tick();
    end
    tx_valid = 0; rx_req = 1; rx_req_core_idx = 2'd1;
    tick();
    rx_req = 0;
    n_total++; if (send_count !== 3'd2 || switch_recv_request !== 1'b1)
      $display("FAIL mid_pre got=%0d/%b exp=2/1", send_count, switch_recv_request); else n_pass++;
    #2 reset = 0;
    #1;
    n_total++; if (send_count !== 3'd0 || switch_send_ready !== 1'b0 || switch_send_data !== '0 || switch_send_core_idx !== 2'd0)
      $display("FAIL mid_send_clear got=%0d/%b exp=0/0", send_count, switch_send_ready); else n_pass++;
    n_total++; if (switch_recv_request !== 1'b0 || switch_recv_core_idx !== 2'd0 || rx_valid !== 1'b0 || idle !== 1'b1)
      $display("FAIL mid_recv_clear got=%b/%0d/%b exp=0/0/0 idle=%b", switch_recv_request, switch_recv_core_idx, rx_valid, idle); else n_pass++;
    @(negedge clock);
    reset = 1;
    tick();
    n_total++; if (idle !== 1'b1 || send_count !== 3'd0 || rx_req_ready !== 1'b1)
      $display("FAIL mid_release got=%b/%0d/%b exp=1/0/1", idle, send_count, rx_req_ready); else n_pass++;
  endtask

`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
  task automatic test_timeout();
    rx_req = 1; rx_req_core_idx = 2'd1;
    tick();
    rx_req = 0;
    for (int i = 0; i < 7; i++) tick();
    n_total++; if (switch_recv_request !== 1'b1 || rx_timeout !== 1'b0)
      $display("FAIL tmo_before got=%b/%b exp=1/0", switch_recv_request, rx_timeout); else n_pass++;
    tick();
    n_total++; if (rx_timeout !== 1'b1 || switch_recv_request !== 1'b0 || recv_count !== 3'd0 || rx_req_ready !== 1'b1)
      $display("FAIL tmo_expire got=%b/%b/%0d exp=1/0/0", rx_timeout, switch_recv_request, recv_count); else n_pass++;
    tick();
    n_total++; if (rx_timeout !== 1'b0) $display("FAIL tmo_pulse got=%b exp=0", rx_timeout); else n_pass++;
    rx_req = 1; rx_req_core_idx = 2'd3;
    tick();
    rx_req = 0;
    for (int i = 0; i < 7; i++) tick();
    switch_recv_ready = 1; switch_recv_data = mk_vec(50);
    tick();
    switch_recv_ready = 0;
    n_total++; if (rx_timeout !== 1'b0 || recv_count !== 3'd1 || rx_core_idx !== 2'd3)
      $display("FAIL tmo_ready_wins got=%b/%0d/%0d exp=0/1/3", rx_timeout, recv_count, rx_core_idx); else n_pass++;
    rx_pop = 1;
    tick();
    rx_pop = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_send_fill_drain();
    test_send_push_pop();
    test_recv_basic();
    test_recv_fill();
    test_reset_mid();
`ifdef MAT_SWITCH_PORT_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
